// File: rtl/seq_detect_param.sv
// Configurable serial pattern detector with KMP-style fallback, optional overlap,
// runtime pattern/length loading and a saturating match counter.
module seq_detect_param #(
  parameter int                 MAX_LEN = 8,
  parameter int                 LEN_W   = 4,
  parameter int                 CNT_W   = 8,
  parameter logic [MAX_LEN-1:0] DEF_PAT = 8'b0000_0110,
  parameter int                 DEF_LEN = 4,
  parameter bit                 DEF_OVL = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               d_in,
  input  logic               en,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pat,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_ovl,
  input  logic               cnt_clr,
  output logic               d_out,
  output logic [LEN_W-1:0]   progress,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cfg_err
);

  logic [MAX_LEN-1:0] pat;
  logic [LEN_W-1:0]   len;
  logic               ovl;

  int   k_base;
  int   next_k;
  logic ok;
  logic cfg_valid;
  logic match_entry;

  // Bit idx of a vector selected by a loop-bounded scan; out-of-range reads 0.
  function automatic logic pat_bit(input logic [MAX_LEN-1:0] p, input int idx);
    logic r;
    r = 1'b0;
    for (int b = 0; b < MAX_LEN; b++)
      if (b == idx) r = p[b];
    return r;
  endfunction

  // Sequence position i maps to pat[len-1-i]. The longest prefix that is a suffix
  // of (first k_base pattern bits, d_in) is the next state; history beyond k_base
  // cannot produce a longer match, so no bit history is stored.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    k_base = (progress == len && !ovl) ? 0 : int'(progress);
    next_k = 0;
    ok     = 1'b0;
    for (int j = 1; j <= MAX_LEN; j++) begin
      if (j <= int'(len) && j <= k_base + 1) begin
        ok = (pat_bit(pat, int'(len) - j) == d_in);
        for (int i = 0; i < MAX_LEN - 1; i++)
          if (i < j - 1 &&
              pat_bit(pat, int'(len) - 1 - (k_base + 1 - j + i)) != pat_bit(pat, int'(len) - 1 - i))
            ok = 1'b0;
        if (ok) next_k = j;
      end
    end
  end

  assign cfg_valid   = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
  assign match_entry = en && !cfg_load && (LEN_W'(next_k) == len);
  assign d_out       = (progress == len);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat       <= DEF_PAT;
      len       <= LEN_W'(DEF_LEN);
      ovl       <= DEF_OVL;
      progress  <= '0;
      match_cnt <= '0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      if (cfg_load) begin
        // A load always swallows the data bit of its cycle, accepted or not.
        if (cfg_valid) begin
          pat      <= cfg_pat;
          len      <= cfg_len;
          ovl      <= cfg_ovl;
          progress <= '0;
        end else begin
          cfg_err <= 1'b1;
        end
      end else if (en) begin
        progress <= LEN_W'(next_k);
      end

      if (cnt_clr)
        match_cnt <= '0;
      else if (match_entry && match_cnt != '1)
        match_cnt <= match_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed table-driven bench for seq_detect_param (counter narrowed to 2 bits so
// saturation is reachable), plus hand-written asynchronous reset sequences.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       d_in, en, cfg_load, cfg_ovl, cnt_clr;
  logic [7:0] cfg_pat;
  logic [3:0] cfg_len;
  logic       d_out, cfg_err;
  logic [3:0] progress;
  logic [1:0] match_cnt;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  seq_detect_param #(.CNT_W(2)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .d_in     (d_in),
    .en       (en),
    .cfg_load (cfg_load),
    .cfg_pat  (cfg_pat),
    .cfg_len  (cfg_len),
    .cfg_ovl  (cfg_ovl),
    .cnt_clr  (cnt_clr),
    .d_out    (d_out),
    .progress (progress),
    .match_cnt(match_cnt),
    .cfg_err  (cfg_err)
  );

  typedef struct {
    logic       ld;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ovl;
    logic       en;
    logic       d;
    logic       clr;
    logic [3:0] exp_k;
    logic       exp_out;
    logic [1:0] exp_cnt;
    logic       exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Generic vector: a configuration load and/or a data bit.
  task automatic add(input logic ld, input logic [7:0] pat, input logic [3:0] len,
                     input logic ovl, input logic e, input logic d, input logic clr,
                     input logic [3:0] k, input logic o, input logic [1:0] c, input logic err);
    vec_t v;
    v.ld = ld; v.pat = pat; v.len = len; v.ovl = ovl; v.en = e; v.d = d; v.clr = clr;
    v.exp_k = k; v.exp_out = o; v.exp_cnt = c; v.exp_err = err;
    vecs.push_back(v);
  endtask

  // Plain data bit with en=1.
  task automatic bit_in(input logic d, input logic [3:0] k, input logic o, input logic [1:0] c);
    add(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, d, 1'b0, k, o, c, 1'b0);
  endtask

  task automatic drive(input logic ld, input logic [7:0] pat, input logic [3:0] len,
                       input logic ovl, input logic e, input logic d, input logic clr);
    @(negedge clk);
    cfg_load = ld; cfg_pat = pat; cfg_len = len; cfg_ovl = ovl;
    en = e; d_in = d; cnt_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [3:0] k, input logic o,
                           input logic [1:0] c, input logic err);
    check({tag, ".progress"},  32'(progress),  32'(k));
    check({tag, ".d_out"},     32'(d_out),     32'(o));
    check({tag, ".match_cnt"}, 32'(match_cnt), 32'(c));
    check({tag, ".cfg_err"},   32'(cfg_err),   32'(err));
  endtask

  initial begin
    // Default 0110, non-overlap: one hit on 0,1,1,0,1,1,0.
    bit_in(0, 1, 0, 0); bit_in(1, 2, 0, 0); bit_in(1, 3, 0, 0); bit_in(0, 4, 1, 1);
    bit_in(1, 0, 0, 1); bit_in(1, 0, 0, 1); bit_in(0, 1, 0, 1);
    add(0, 8'h00, 4'd0, 0, 0, 0, 0, 1, 0, 1, 0);            // en=0 holds
    add(0, 8'h00, 4'd0, 0, 0, 1, 1, 1, 0, 0, 0);            // cnt_clr alone
    // 101 overlap; load coincident with en=1 discards the bit.
    add(1, 8'b101, 4'd3, 1, 1, 1, 0, 0, 0, 0, 0);
    bit_in(1, 1, 0, 0); bit_in(0, 2, 0, 0); bit_in(1, 3, 1, 1); bit_in(0, 2, 0, 1); bit_in(1, 3, 1, 2);
    // 101 non-overlap.
    add(1, 8'b101, 4'd3, 0, 0, 0, 1, 0, 0, 0, 0);
    bit_in(1, 1, 0, 0); bit_in(0, 2, 0, 0); bit_in(1, 3, 1, 1); bit_in(0, 0, 0, 1); bit_in(1, 1, 0, 1);
    // 1101: third 1 falls back to k=2, not 0.
    add(1, 8'b1101, 4'd4, 0, 0, 0, 1, 0, 0, 0, 0);
    bit_in(1, 1, 0, 0); bit_in(1, 2, 0, 0); bit_in(1, 2, 0, 0); bit_in(0, 3, 0, 0); bit_in(1, 4, 1, 1);
    // Rejected loads (len 0 with en, len MAX_LEN+1) leave state and config alone.
    add(1, 8'h00, 4'd0, 1, 1, 1, 0, 4, 1, 1, 1);
    add(0, 8'h00, 4'd0, 0, 0, 0, 0, 4, 1, 1, 0);
    add(1, 8'hFF, 4'd9, 1, 0, 0, 0, 4, 1, 1, 1);
    bit_in(1, 1, 0, 1); bit_in(1, 2, 0, 1); bit_in(0, 3, 0, 1); bit_in(1, 4, 1, 2);
    // Pattern bits above len-1 ignored.
    add(1, 8'hF6, 4'd4, 0, 0, 0, 1, 0, 0, 0, 0);
    bit_in(0, 1, 0, 0); bit_in(1, 2, 0, 0); bit_in(1, 3, 0, 0); bit_in(0, 4, 1, 1);
    // len=1 "1": a hit every bit; saturation at 3, clr wins over a hit.
    add(1, 8'h01, 4'd1, 0, 0, 0, 1, 0, 0, 0, 0);
    bit_in(1, 1, 1, 1); bit_in(1, 1, 1, 2); bit_in(1, 1, 1, 3); bit_in(1, 1, 1, 3); bit_in(1, 1, 1, 3);
    add(0, 8'h00, 4'd0, 0, 1, 1, 1, 1, 1, 0, 0);
    bit_in(0, 0, 0, 0);
    add(0, 8'h00, 4'd0, 0, 0, 1, 0, 0, 0, 0, 0);
    // len=MAX_LEN 10100101 overlap: border "101" then extend with 0 -> k=4.
    add(1, 8'hA5, 4'd8, 1, 0, 0, 0, 0, 0, 0, 0);
    bit_in(1, 1, 0, 0); bit_in(0, 2, 0, 0); bit_in(1, 3, 0, 0); bit_in(0, 4, 0, 0);
    bit_in(0, 5, 0, 0); bit_in(1, 6, 0, 0); bit_in(0, 7, 0, 0); bit_in(1, 8, 1, 1);
    bit_in(0, 4, 0, 1);

    rst = 1'b1; en = 0; d_in = 0; cfg_load = 0; cfg_pat = '0; cfg_len = '0; cfg_ovl = 0; cnt_clr = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 4'd0, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].ld, vecs[i].pat, vecs[i].len, vecs[i].ovl, vecs[i].en, vecs[i].d, vecs[i].clr);
      check_all($sformatf("vec%0d", i), vecs[i].exp_k, vecs[i].exp_out, vecs[i].exp_cnt, vecs[i].exp_err);
    end

    // Asynchronous reset between edges restores the default 0110 configuration.
    @(negedge clk);
    en = 0; cfg_load = 0; cnt_clr = 0;
    #2 rst = 1'b1;
    #1 check_all("async_rst1", 4'd0, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 8'h00, 4'd0, 0, 1, 0, 0);
    drive(0, 8'h00, 4'd0, 0, 1, 1, 0);
    drive(0, 8'h00, 4'd0, 0, 1, 1, 0);
    check("pre_rst.progress", 32'(progress), 32'd3);
    #2 rst = 1'b1;                       // mid-cycle, no clock edge involved
    #1 check_all("async_rst2", 4'd0, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 8'h00, 4'd0, 0, 1, 0, 0);
    drive(0, 8'h00, 4'd0, 0, 1, 1, 0);
    drive(0, 8'h00, 4'd0, 0, 1, 1, 0);
    check_all("post_rst3", 4'd3, 1'b0, 2'd0, 1'b0);
    drive(0, 8'h00, 4'd0, 0, 1, 0, 0);
    check_all("post_rst4", 4'd4, 1'b1, 2'd1, 1'b0);
    drive(0, 8'h00, 4'd0, 0, 0, 1, 0);
    check_all("post_rst_hold", 4'd4, 1'b1, 2'd1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
